// File: rtl/rgb_led_pwm_sched_pkg.sv
// Shared constants and types for the RGB LED dimmer.
// Channel index equals the led pin bit.
package rgb_led_pkg;

  localparam int NUM_CH = 12;
  localparam int ADDR_W = 4;
  localparam int DUTY_W_DEF = 4;

  localparam int LED_R_BASE = 0;
  localparam int LED_G_BASE = 4;
  localparam int LED_B_BASE = 8;
  localparam int LEDS_PER_COLOR = 4;

  typedef logic [DUTY_W_DEF-1:0] duty_t;
  typedef logic [ADDR_W-1:0] ch_addr_t;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } color_e;

  function automatic ch_addr_t ch_idx(
    input color_e c,
    input logic [1:0] n
  );
    ch_addr_t base;
    base = '0;
    unique case (c)
      COL_R: base = ADDR_W'(LED_R_BASE);
      COL_G: base = ADDR_W'(LED_G_BASE);
      COL_B: base = ADDR_W'(LED_B_BASE);
      default: base = '0;
    endcase
    return base + ADDR_W'(n);
  endfunction

endpackage

// File: rtl/rgb_led_pwm_sched_if.sv
// Duty write port between the SoC bus bridge and the dimmer.
// Plain valid/ready with a registered error pulse back.
interface rgb_led_pwm_sched_if
  import rgb_led_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DUTY_W-1:0] wr_data;
  logic              wr_err;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready,
    input  wr_err
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready,
    output wr_err
  );

endinterface

// File: rtl/rgb_led_pwm_sched_timebase.sv
// Prescaler plus PWM period counter; reusable by other dimmers.
// commit marks the last tick of a period.
module pwm_timebase #(
  parameter int PRESCALE = 4,
  parameter int DUTY_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              tick,
  output logic              commit,
  output logic [DUTY_W-1:0] pwm_cnt
);

  localparam int PS_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX =
    PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;

  assign tick   = (presc == PS_MAX);
  assign commit = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end else begin
        presc   <= presc + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_led_pwm_sched.sv
// 12-channel LED dimmer: shadow duties load into active
// duties only at period end, so no period is ever glitched.
module rgb_led_pwm_sched
  import rgb_led_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int DUTY_W   = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rgb_led_pwm_sched_if.slave wr,
  input  logic              enable,
  output logic              period_start,
  output logic [NUM_CH-1:0] led
);

  logic              tick;
  logic              commit;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              fire;
  logic              bad_addr;

  logic [DUTY_W-1:0] shadow [NUM_CH];
  logic [DUTY_W-1:0] active [NUM_CH];

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .DUTY_W   (DUTY_W)
  ) u_timebase (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .commit  (commit),
    .pwm_cnt (pwm_cnt)
  );

  assign fire     = wr.wr_valid && wr.wr_ready;
  assign bad_addr = (wr.wr_addr >= ADDR_W'(NUM_CH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr.wr_ready  <= 1'b0;
      wr.wr_err    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wr.wr_ready  <= 1'b1;
      wr.wr_err    <= fire && bad_addr;
      period_start <= tick && commit;
    end
  end

  // commit reads the pre-write shadow on a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick && commit)
          active[i] <= shadow[i];
        if (fire && wr.wr_addr == ADDR_W'(i))
          shadow[i] <= wr.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        led[i] <= enable && (pwm_cnt < active[i]);
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_sched.sv
// Bench for rgb_led_pwm_sched: time-based reference model
// of duty periods, directed steps plus random writes.
module tb_rgb_led_pwm_sched;
  import rgb_led_pkg::*;

  localparam int PS  = 4;
  localparam int DW  = 4;
  localparam int TPC = PS;
  localparam int PER = PS * (1 << DW);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              period_start;
  logic [NUM_CH-1:0] led;

  rgb_led_pwm_sched_if #(.DUTY_W(DW)) wr_if ();

  rgb_led_pwm_sched #(
    .PRESCALE (PS),
    .DUTY_W   (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr_if),
    .enable       (enable),
    .period_start (period_start),
    .led          (led)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   t     = 0;
  int   shd     [NUM_CH];
  int   act     [NUM_CH];
  int   hi_acc  [NUM_CH];
  int   hi_last [NUM_CH];
  logic rdy_m = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h",
             tag, t, got, exp);
    end
  endtask

  // One clock: predict from elapsed time, then compare.
  task automatic cyc();
    int          ph;
    int          cnt;
    int          a;
    logic [11:0] el;
    logic        eps;
    logic        eerr;
    logic        fire;
    ph   = t % PER;
    cnt  = ph / TPC;
    el   = '0;
    for (int i = 0; i < NUM_CH; i++)
      el[i] = enable && (cnt < act[i]);
    eps  = (ph == PER - 1);
    fire = wr_if.wr_valid && rdy_m;
    a    = int'(wr_if.wr_addr);
    eerr = fire && (a >= NUM_CH);
    if (ph == PER - 1)
      for (int i = 0; i < NUM_CH; i++) act[i] = shd[i];
    if (fire && a < NUM_CH)
      shd[a] = int'(wr_if.wr_data);
    @(posedge clk);
    #1;
    t++;
    rdy_m = 1'b1;
    chk("led", 32'(led), 32'(el));
    chk("period_start", 32'(period_start), 32'(eps));
    chk("wr_err", 32'(wr_if.wr_err), 32'(eerr));
    chk("wr_ready", 32'(wr_if.wr_ready), 32'(rdy_m));
    for (int i = 0; i < NUM_CH; i++)
      hi_acc[i] += int'(led[i]);
    if (t % PER == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hi_last[i] = hi_acc[i];
        hi_acc[i]  = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_if.wr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t     = 0;
    rdy_m = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      shd[i]     = 0;
      act[i]     = 0;
      hi_acc[i]  = 0;
      hi_last[i] = 0;
    end
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_ready", 32'(wr_if.wr_ready), 32'd0);
    chk("rst_err", 32'(wr_if.wr_err), 32'd0);
  endtask

  task automatic wr(input int addr, input int data);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = ADDR_W'(addr);
    wr_if.wr_data  = DW'(data);
    cyc();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = ADDR_W'($urandom);
    wr_if.wr_data  = DW'($urandom);
  endtask

  task automatic run_to_phase(input int p);
    for (int k = 0; k < PER; k++) begin
      if (t % PER == p) break;
      cyc();
    end
  endtask

  initial begin
    int ch0;
    int ch2;
    int ch5;
    int ch11;
    ch0  = int'(ch_idx(COL_R, 2'd0));
    ch2  = int'(ch_idx(COL_R, 2'd2));
    ch5  = int'(ch_idx(COL_G, 2'd1));
    ch11 = int'(ch_idx(COL_B, 2'd3));
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;

    // 1: reset and idle
    do_reset();
    do_reset();
    repeat (130) cyc();
    chk("idle_hi0", 32'(hi_last[0]), 32'd0);

    // 2: duties take effect only after the next commit
    enable = 1'b1;
    wr(ch0, 8);
    wr(ch11, 15);
    run_to_phase(0);
    chk("pre_commit_hi0", 32'(hi_last[0]), 32'd0);
    repeat (PER) cyc();
    chk("duty8_hi", 32'(hi_last[ch0]), 32'd32);
    chk("duty15_hi", 32'(hi_last[ch11]), 32'd60);

    // 3: write in the commit cycle lands one period late
    run_to_phase(PER - 1);
    wr(ch5, 3);
    repeat (PER) cyc();
    chk("commit_wr_old", 32'(hi_last[ch5]), 32'd0);
    repeat (PER) cyc();
    chk("commit_wr_new", 32'(hi_last[ch5]), 32'd12);

    // 4: out-of-range writes only pulse wr_err
    wr(12, 7);
    cyc();
    wr(15, 9);
    repeat (3) cyc();
    run_to_phase(0);
    repeat (PER) cyc();
    chk("bad_addr_hi0", 32'(hi_last[ch0]), 32'd32);
    chk("bad_addr_hi5", 32'(hi_last[ch5]), 32'd12);

    // 5: enable gating stays in phase
    wr(ch2, 10);
    run_to_phase(0);
    run_to_phase(20);
    cyc();
    chk("en_on_led2", 32'(led[ch2]), 32'd1);
    enable = 1'b0;
    cyc();
    chk("en_off_led2", 32'(led[ch2]), 32'd0);
    repeat (5) cyc();
    enable = 1'b1;
    repeat (PER) cyc();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_addr  = ADDR_W'($urandom_range(0, 15));
      wr_if.wr_data  = DW'($urandom);
      if ($urandom_range(0, 31) == 0)
        enable = ~enable;
      cyc();
    end
    wr_if.wr_valid = 1'b0;
    enable = 1'b1;
    wr(ch0, 9);
    run_to_phase(0);

    // 6: reset mid-period at pwm_cnt = 9
    run_to_phase(9 * TPC);
    do_reset();
    repeat (2 * PER + 5) cyc();
    chk("post_rst_hi0", 32'(hi_last[ch0]), 32'd0);
    chk("post_rst_hi2", 32'(hi_last[ch2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
